// File: rtl/alu_issue_scheduler.sv
// -----------------------------------------------------------------------------
// alu_issue_scheduler
//   Reservation station feeding the ALU. Holds up to DEPTH dispatched ops, and
//   wakes their pending source operands from CDB broadcasts. Each cycle it
//   moves the oldest fully-ready entry into a registered valid/ready issue
//   stage. Dispatch order is kept in an age matrix, so the slot an op lands in
//   never affects its priority.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   flush             synchronous squash of all entries and the issue register
//   disp_*            dispatch request (valid/ready) with opcode, two source
//                     operands (ready flag, producer tag, value) and dest tag;
//                     rs2 is carried in the upper half of the packed buses
//   cdb_*             result broadcast (valid, tag, value)
//   iss_*             issue register payload (valid/ready handshake to ALU)
//   occupancy         valid entries, excluding the issue register
// -----------------------------------------------------------------------------
module alu_issue_scheduler #(
   parameter int DEPTH  = 8,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic [OP_W-1:0]          disp_op,
   input  logic [1:0]               disp_src_rdy,
   input  logic [2*TAG_W-1:0]       disp_src_tag,
   input  logic [2*DATA_W-1:0]      disp_src_val,
   input  logic [TAG_W-1:0]         disp_dest_tag,
   input  logic                     cdb_valid,
   input  logic [TAG_W-1:0]         cdb_tag,
   input  logic [DATA_W-1:0]        cdb_val,
   output logic                     iss_valid,
   input  logic                     iss_ready,
   output logic [OP_W-1:0]          iss_op,
   output logic [DATA_W-1:0]        iss_a,
   output logic [DATA_W-1:0]        iss_b,
   output logic [TAG_W-1:0]         iss_dest_tag,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int OCC_W = IDX_W + 1;

   // Entry state. older_q[i][j] = 1 means entry i was dispatched before j.
   logic [DEPTH-1:0]              valid_q;
   logic [DEPTH-1:0]              older_q [DEPTH];
   logic [OP_W-1:0]               op_q    [DEPTH];
   logic [TAG_W-1:0]              dest_q  [DEPTH];
   logic [1:0]                    rdy_q   [DEPTH];
   logic [1:0][TAG_W-1:0]         tag_q   [DEPTH];
   logic [1:0][DATA_W-1:0]        val_q   [DEPTH];

   logic [DEPTH-1:0] ready_vec;
   logic [DEPTH-1:0] sel_oh;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] sel_idx;
   logic             any_sel;
   logic             disp_fire;
   logic             can_move;
   logic             move;

   // Registered occupancy only: a slot freed this cycle is not reusable until
   // the next one, which keeps disp_ready off any combinational path.
   assign disp_ready = (occupancy < OCC_W'(DEPTH));
   assign disp_fire  = disp_valid && disp_ready;
   assign can_move   = !iss_valid || iss_ready;
   assign move       = can_move && any_sel;

   // Lowest-index free slot (scan downwards so the last hit is the lowest).
   always_comb begin
      // NOTE: every combinationally assigned variable gets a default first so
      // no path through the block leaves it unassigned (which would infer a latch).
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = IDX_W'(i);
      end
   end

   // Oldest-ready select: an entry wins if no other ready entry is older.
   always_comb begin
      ready_vec = '0;
      sel_oh    = '0;
      sel_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ready_vec[i] = valid_q[i] && (rdy_q[i] == 2'b11);
      end
      for (int i = 0; i < DEPTH; i++) begin
         sel_oh[i] = ready_vec[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (ready_vec[j] && older_q[j][i]) sel_oh[i] = 1'b0;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (sel_oh[i]) sel_idx = IDX_W'(i);
      end
   end

   assign any_sel = |sel_oh;

   // Control state: entry valid bits, age matrix, issue register, occupancy.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         valid_q      <= '0;
         iss_valid    <= 1'b0;
         iss_op       <= '0;
         iss_a        <= '0;
         iss_b        <= '0;
         iss_dest_tag <= '0;
         occupancy    <= '0;
         for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
      end else if (flush) begin
         valid_q   <= '0;
         iss_valid <= 1'b0;
         occupancy <= '0;
      end else begin
         if (move) valid_q[sel_idx] <= 1'b0;
         if (disp_fire) begin
            valid_q[free_idx] <= 1'b1;
            // New entry is younger than everything: clear its row, set its column.
            for (int j = 0; j < DEPTH; j++) begin
               if (IDX_W'(j) == free_idx) older_q[j] <= '0;
               else                       older_q[j][free_idx] <= 1'b1;
            end
         end
         // Issue register holds while a payload is stalled (valid && !ready).
         if (can_move) begin
            iss_valid <= any_sel;
            if (any_sel) begin
               iss_op       <= op_q[sel_idx];
               iss_a        <= val_q[sel_idx][0];
               iss_b        <= val_q[sel_idx][1];
               iss_dest_tag <= dest_q[sel_idx];
            end
         end
         occupancy <= occupancy + OCC_W'(disp_fire) - OCC_W'(move);
      end
   end

   // Entry payload: dispatch write with same-cycle CDB bypass, and wakeup.
   // NOTE: this storage is deliberately not reset; valid_q gates every use of
   // it, so clearing the arrays on reset would only add reset fan-out.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!flush && disp_fire && (free_idx == IDX_W'(i))) begin
            op_q[i]   <= disp_op;
            dest_q[i] <= disp_dest_tag;
            for (int s = 0; s < 2; s++) begin
               tag_q[i][s] <= disp_src_tag[s*TAG_W +: TAG_W];
               if (disp_src_rdy[s]) begin
                  rdy_q[i][s] <= 1'b1;
                  val_q[i][s] <= disp_src_val[s*DATA_W +: DATA_W];
               end else if (cdb_valid && (cdb_tag == disp_src_tag[s*TAG_W +: TAG_W])) begin
                  rdy_q[i][s] <= 1'b1;
                  val_q[i][s] <= cdb_val;
               end else begin
                  rdy_q[i][s] <= 1'b0;
               end
            end
         end else if (!flush && valid_q[i]) begin
            for (int s = 0; s < 2; s++) begin
               if (cdb_valid && !rdy_q[i][s] && (tag_q[i][s] == cdb_tag)) begin
                  rdy_q[i][s] <= 1'b1;
                  val_q[i][s] <= cdb_val;
               end
            end
         end
      end
   end

endmodule
